// File: rtl/mat_ctrl_pkg.sv
// mat_ctrl_pkg: shared FSM state encoding and drain-length helpers for the matrix feed control
package mat_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;
  function automatic int drain_cycles(int dim);
    return 2 * dim - 1;
  endfunction
  function automatic int drain_w(int dim);
    return $clog2(2 * dim);
  endfunction
endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// systolic_feed_ctrl_if: job handshake, source handshake and lane-FIFO controls of the feed controller
interface systolic_feed_ctrl_if #(parameter int CNT_W = 8);
  logic start;
  logic [CNT_W-1:0] num_vecs;
  logic in_valid;
  logic in_ready;
  logic stall;
  logic fifo_en;
  logic fifo_zero;
  logic acc_clr;
  logic busy;
  logic done;
  modport master (output start, num_vecs, in_valid, stall,
                  input in_ready, fifo_en, fifo_zero, acc_clr, busy, done);
  modport slave (input start, num_vecs, in_valid, stall,
                 output in_ready, fifo_en, fifo_zero, acc_clr, busy, done);
endinterface

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: feeds num_vecs vectors into the lane FIFOs, then pushes 2*DIM-1 zero bubbles to drain the array
module systolic_feed_ctrl
  import mat_ctrl_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  systolic_feed_ctrl_if.slave bus
);
  localparam int DW = drain_w(DIM);
  localparam logic [DW-1:0] DC = DW'(drain_cycles(DIM));
  state_e r_state, w_next;
  logic [CNT_W-1:0] r_rem, w_rem;
  logic [DW-1:0] r_drn, w_drn;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_rem <= '0;
      r_drn <= '0;
    end else begin
      r_state <= w_next;
      r_rem <= w_rem;
      r_drn <= w_drn;
    end
  // stall freezes everything except the unconditional DONE->IDLE step
  always_comb begin
    w_next = r_state;
    w_rem = r_rem;
    w_drn = r_drn;
    bus.in_ready = 1'b0;
    bus.fifo_en = 1'b0;
    bus.fifo_zero = 1'b0;
    bus.acc_clr = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_IDLE:
        if (bus.start && !bus.stall && !rst) begin
          bus.acc_clr = 1'b1;
          w_rem = bus.num_vecs;
          w_next = (bus.num_vecs == '0) ? S_DONE : S_LOAD;
        end
      S_LOAD: begin
        bus.busy = 1'b1;
        bus.in_ready = !bus.stall;
        if (bus.in_valid && !bus.stall) begin
          bus.fifo_en = 1'b1;
          w_rem = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_next = S_DRAIN;
            w_drn = DC;
          end
        end
      end
      S_DRAIN: begin
        bus.busy = 1'b1;
        bus.fifo_zero = 1'b1;
        bus.fifo_en = !bus.stall;
        if (!bus.stall) begin
          w_drn = r_drn - DW'(1);
          if (r_drn == DW'(1)) w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: scoreboard bench for the feed controller at DIM=4
module tb_systolic_feed_ctrl;
  import mat_ctrl_pkg::*;
  localparam int DIM = 4;
  localparam int CNT_W = 8;
  localparam int DC = drain_cycles(DIM);
  typedef struct {int lat; int d; int z;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  systolic_feed_ctrl_if #(.CNT_W(CNT_W)) bus();
  systolic_feed_ctrl #(.DIM(DIM), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] outs();
    return {bus.acc_clr, bus.fifo_en, bus.fifo_zero, bus.done, bus.busy, bus.in_ready};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // monitor: measures each job from acc_clr to done and checks it against the queued expectation
  int t, dcnt, zcnt;
  bit act = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst) act = 1'b0;
    else begin
      if (act) t++;
      if (bus.fifo_en && !bus.fifo_zero) dcnt++;
      if (bus.fifo_en && bus.fifo_zero) zcnt++;
      if (bus.done) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          chk("lat", t, e.lat);
          chk("data_en", dcnt, e.d);
          chk("drain_en", zcnt, e.z);
        end
        act = 1'b0;
      end
      if (bus.acc_clr) begin
        act = 1'b1;
        t = 0;
        dcnt = 0;
        zcnt = 0;
      end
    end
  end
  task automatic run_job(int n, logic [15:0] vpat, int st_from, int st_len, int exp_lat);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    sb.push_back('{exp_lat, n, (n == 0) ? 0 : DC});
    bus.start = 1'b1;
    bus.num_vecs = CNT_W'(n);
    bus.stall = 1'b0;
    bus.in_valid = 1'b0;
    while (!seen && c < 300) begin
      @(negedge clk);
      if (bus.stall) chk("stall_en", bus.fifo_en, 0);
      if (bus.busy && !bus.fifo_zero) chk("load_en", bus.fifo_en, bus.in_valid && !bus.stall);
      if (bus.done) begin
        chk("done_cyc", c, exp_lat);
        seen = 1'b1;
      end
      cyc();
      c++;
      bus.start = 1'b0;
      bus.in_valid = (c <= 16) ? vpat[c-1] : 1'b1;
      bus.stall = (c >= st_from && c < st_from + st_len);
    end
    bus.stall = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask
  initial begin
    int acc_n, acc2, dn, c;
    bus.start = 1'b1;
    bus.num_vecs = 8'd3;
    bus.in_valid = 1'b1;
    bus.stall = 1'b0;
    @(negedge clk);
    chk("rst_outs", outs(), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    cyc();
    // basic job: 3 vectors, DIM=4 -> done at cycle 11
    sb.push_back('{11, 3, DC});
    bus.start = 1'b1;
    bus.num_vecs = 8'd3;
    bus.in_valid = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("A_c%0d", k), outs(),
          {k == 0, k >= 1 && k <= 10, k >= 4 && k <= 10, k == 11, k >= 1 && k <= 10, k >= 1 && k <= 3});
      cyc();
      bus.start = 1'b0;
    end
    // empty job
    sb.push_back('{1, 0, 0});
    bus.start = 1'b1;
    bus.num_vecs = 8'd0;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("B_c%0d", k), outs(), {k == 0, 1'b0, 1'b0, k == 1, 1'b0, 1'b0});
      cyc();
      bus.start = 1'b0;
    end
    run_job(2, 16'h000A, 0, 0, 12);
    run_job(3, 16'hFFFF, 6, 3, 14);
    run_job(1, 16'hFFFF, 2, 2, 11);
    run_job(255, 16'hFFFF, 0, 0, 263);
    // reset in the middle of a 5-vector load
    bus.start = 1'b1;
    bus.num_vecs = 8'd5;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("E_acc", bus.acc_clr, 1);
    cyc();
    bus.start = 1'b0;
    @(negedge clk);
    chk("E_xfer", bus.fifo_en, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("E_rst_outs", outs(), 0);
    @(negedge clk);
    chk("E_rst_hold", outs(), 0);
    rst = 1'b0;
    cyc();
    run_job(2, 16'hFFFF, 0, 0, 10);
    // start held across two back-to-back jobs
    sb.push_back('{10, 2, DC});
    sb.push_back('{10, 2, DC});
    bus.start = 1'b1;
    bus.num_vecs = 8'd2;
    bus.in_valid = 1'b1;
    acc_n = 0;
    acc2 = -1;
    dn = 0;
    c = 0;
    while (dn < 2 && c < 100) begin
      @(negedge clk);
      if (bus.acc_clr) begin
        acc_n++;
        if (acc_n == 2) acc2 = c;
      end
      if (bus.done) dn++;
      cyc();
      c++;
    end
    bus.start = 1'b0;
    chk("F_acc_n", acc_n, 2);
    chk("F_acc2", acc2, 11);
    chk("F_dones", dn, 2);
    cyc();
    cyc();
    chk("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
